npu_lut_bank: RTL

Parametrised multi-lane lookup table for the NPU core's activation and quantisation stage. It replaces the fixed 19-entry, 32-lane combinational table with a configurable, registered-read table. Table contents arrive through a burst-load handshake driven by the controller. Each of `LANES` datapath lanes gets one lookup per cycle, plus a dedicated registered quantisation-encode word.

---
 rtl/npu_lut_pkg.sv | 20 ++
 rtl/npu_lut_load_fsm.sv | 90 +++++++++
 rtl/npu_lut_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/npu_lut_pkg.sv
// Shared state type, default parameters and lane-slicing helper for the NPU lookup-table bank.
package npu_lut_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } lut_state_e;

  localparam int LUT_DATA_W   = 24;
  localparam int LUT_ADDR_W   = 5;
  localparam int LUT_DEPTH    = 19;
  localparam int LUT_LANES    = 32;
  localparam int LUT_QENC_IDX = 18;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/npu_lut_load_fsm.sv
// Burst-load controller: checks request bounds, counts beats and generates table writes.
// state | meaning
// IDLE  | waiting for ld_start; out-of-range or empty requests pulse ld_err
// LOAD  | ld_ready high, each accepted beat writes one entry
// DONE  | ld_done pulse, returns to IDLE next cycle
module npu_lut_load_fsm
  import npu_lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DEPTH  = LUT_DEPTH
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(DEPTH);

  lut_state_e        state;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   left_q;
  logic [ADDR_W+1:0] end_addr;
  logic              req_bad;

  assign end_addr = {2'b00, ld_base} + {1'b0, ld_len};
  assign req_bad  = (ld_len == '0) || (end_addr > DEPTH_L);
  assign wr_en    = ld_ready & ld_valid;
  assign wr_addr  = wr_ptr_q;

  // left_q counts remaining beats down; the beat seen at a count of one is the last
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wr_ptr_q <= '0;
      left_q   <= '0;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_start) begin
            if (req_bad) begin
              ld_err <= 1'b1;
            end else begin
              state    <= ST_LOAD;
              wr_ptr_q <= ld_base;
              left_q   <= ld_len;
              ld_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            left_q   <= left_q - (ADDR_W+1)'(1);
            if (left_q == (ADDR_W+1)'(1)) begin
              state    <= ST_DONE;
              ld_ready <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          ld_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/npu_lut_bank.sv
// Multi-lane registered lookup table with burst load and a mirrored quantisation-encode word.
// Define LUT_RST_CLEAR_EN to have rst clear every entry and q_encode.
module npu_lut_bank
  import npu_lut_pkg::*;
#(
  parameter int DATA_W   = LUT_DATA_W,
  parameter int ADDR_W   = LUT_ADDR_W,
  parameter int DEPTH    = LUT_DEPTH,
  parameter int LANES    = LUT_LANES,
  parameter int QENC_IDX = LUT_QENC_IDX
) (
  input  logic                    clka,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic [ADDR_W-1:0]       ld_base,
  input  logic [ADDR_W:0]         ld_len,
  input  logic                    ld_valid,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  output logic                    ld_done,
  output logic                    ld_err,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [LANES*ADDR_W-1:0] rd_addr,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic                    rd_vld,
  output logic [LANES-1:0]        rd_oob,
  output logic [DATA_W-1:0]       q_encode
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] QENC_A  = ADDR_W'(QENC_IDX);

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [LANES*DATA_W-1:0] rd_next;
  logic [LANES-1:0]        oob_next;

  npu_lut_load_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_load_fsm (
    .clka     (clka),
    .rst      (rst),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_len   (ld_len),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr)
  );

`ifdef LUT_RST_CLEAR_EN
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      q_encode <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= ld_data;
      if (wr_addr == QENC_A) q_encode <= ld_data;
    end
  end
`else
  // No reset term so the array can map onto distributed RAM
  always_ff @(posedge clka) begin
    if (wr_en) begin
      mem[wr_addr] <= ld_data;
      if (wr_addr == QENC_A) q_encode <= ld_data;
    end
  end
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [ADDR_W-1:0] addr;
    assign addr        = rd_addr[lane_lsb(g, ADDR_W) +: ADDR_W];
    assign oob_next[g] = ({1'b0, addr} >= DEPTH_C);
    assign rd_next[lane_lsb(g, DATA_W) +: DATA_W] = oob_next[g] ? '0 : mem[addr];
  end

  // Reads sample the array before a same-edge write lands, giving the old value
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_oob  <= '0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data <= rd_next;
        rd_oob  <= oob_next;
      end
    end
  end

endmodule
